// File: rtl/header_loader_pkg.sv
// Shared widths and load-state encoding for the header loader and the keccak stage.
package header_loader_pkg;
  localparam int DATA_W      = 32;
  localparam int HDR_WORDS   = 19;
  localparam int FRAME_WORDS = HDR_WORDS + 2;
  localparam int HDR_W       = DATA_W * HDR_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } load_state_t;
endpackage

// File: rtl/header_outreg.sv
// Output holding register: keeps one job stable for the consumer until job_taken.
module header_outreg
  import header_loader_pkg::*;
#(
  parameter int HDR_WORDS = header_loader_pkg::HDR_WORDS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic [DATA_W*HDR_WORDS-1:0]   header_in,
  input  logic [DATA_W-1:0]             nonce_in,
  input  logic [DATA_W-1:0]             target_in,
  input  logic                          job_taken,
  output logic [DATA_W*HDR_WORDS-1:0]   header,
  output logic [DATA_W-1:0]             nonce,
  output logic [DATA_W-1:0]             target1,
  output logic                          job_valid
);

  // A new load wins over job_taken so back-to-back jobs keep job_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      header    <= '0;
      nonce     <= '0;
      target1   <= '0;
      job_valid <= 1'b0;
    end else if (load) begin
      header    <= header_in;
      nonce     <= nonce_in;
      target1   <= target_in;
      job_valid <= 1'b1;
    end else if (job_valid && job_taken) begin
      job_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/header_loader.sv
// Collects framed 32-bit words into a load buffer and hands complete jobs to the output register.
module header_loader
  import header_loader_pkg::*;
#(
  parameter int HDR_WORDS   = header_loader_pkg::HDR_WORDS,
  parameter int FRAME_WORDS = HDR_WORDS + 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             word_in,
  input  logic                          word_valid,
  input  logic                          sof,
  output logic                          word_ready,
  output logic [DATA_W*HDR_WORDS-1:0]   header,
  output logic [DATA_W-1:0]             nonce,
  output logic [DATA_W-1:0]             target1,
  output logic                          job_valid,
  input  logic                          job_taken,
  output logic                          frame_err
);

  localparam int HDR_BITS = DATA_W * HDR_WORDS;
  localparam int CNT_W    = $clog2(FRAME_WORDS);

  load_state_t             state;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_W-1:0]       hdr_mem [HDR_WORDS];
  logic [DATA_W-1:0]       nonce_buf;
  logic [DATA_W-1:0]       target_buf;
  logic [HDR_BITS-1:0]     hdr_flat;

  logic                    xfer;
  logic                    store_en;
  logic [CNT_W-1:0]        wr_idx;
  logic                    load_job;

  assign word_ready = (state != ST_FULL);
  assign xfer       = word_valid && word_ready;
  assign load_job   = (state == ST_FULL) && (!job_valid || job_taken);

  always_comb begin
    store_en = 1'b0;
    wr_idx   = cnt;
    if (xfer && (sof || state == ST_LOAD)) begin
      store_en = 1'b1;
      wr_idx   = sof ? '0 : cnt;
    end
  end

  // ---- load FSM: control only, reset asynchronously ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (sof) begin
              cnt   <= CNT_W'(1);
              state <= ST_LOAD;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            if (sof) begin
              frame_err <= 1'b1;
              cnt       <= CNT_W'(1);
            end else if (cnt == CNT_W'(FRAME_WORDS - 1)) begin
              cnt   <= '0;
              state <= ST_FULL;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_FULL: begin
          if (load_job) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // ---- load buffer: data path, validity is tracked by the FSM ----
  always_ff @(posedge clk) begin
    if (store_en) begin
      if (wr_idx < CNT_W'(HDR_WORDS)) begin
        hdr_mem[wr_idx] <= word_in;
      end else if (wr_idx == CNT_W'(HDR_WORDS)) begin
        nonce_buf <= word_in;
      end else begin
        target_buf <= word_in;
      end
    end
  end

  // Word 0 occupies the most significant slice of the header.
  for (genvar k = 0; k < HDR_WORDS; k++) begin : g_pack
    assign hdr_flat[HDR_BITS-1-DATA_W*k -: DATA_W] = hdr_mem[k];
  end

  // ---- output stage ----
  header_outreg #(
    .HDR_WORDS (HDR_WORDS)
  ) u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_job),
    .header_in (hdr_flat),
    .nonce_in  (nonce_buf),
    .target_in (target_buf),
    .job_taken (job_taken),
    .header    (header),
    .nonce     (nonce),
    .target1   (target1),
    .job_valid (job_valid)
  );

endmodule

// File: tb/tb_header_loader.sv
// Directed and randomized bench for header_loader against a frame-level reference model.
module tb_header_loader;
  localparam int HW = 608;
  localparam int FW = 21;
  localparam int HWORDS = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   word_in = '0;
  logic          word_valid = 1'b0;
  logic          sof = 1'b0;
  logic          word_ready;
  logic [HW-1:0] header;
  logic [31:0]   nonce;
  logic [31:0]   target1;
  logic          job_valid;
  logic          job_taken = 1'b0;
  logic          frame_err;

  int checks = 0;
  int errors = 0;

  header_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_in    (word_in),
    .word_valid (word_valid),
    .sof        (sof),
    .word_ready (word_ready),
    .header     (header),
    .nonce      (nonce),
    .target1    (target1),
    .job_valid  (job_valid),
    .job_taken  (job_taken),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Reference model: a frame being collected, one complete frame waiting, one job presented.
  logic [31:0] cur_q [$];
  bit          collecting;
  bit          held_v;
  logic [31:0] held  [FW];
  bit          out_v;
  logic [31:0] out_w [FW];
  bit          exp_err;
  bit          last_acc;

  logic [31:0] tx_w [$];
  bit          tx_s [$];
  int          err_cnt;

  task automatic model_reset();
    cur_q.delete();
    collecting = 0;
    held_v     = 0;
    out_v      = 0;
    exp_err    = 0;
    for (int k = 0; k < FW; k++) begin
      held[k]  = '0;
      out_w[k] = '0;
    end
  endtask

  task automatic model_step(input logic [31:0] w, input bit wv, input bit s, input bit tk);
    last_acc = wv && !held_v;
    exp_err  = 0;
    if (held_v && (!out_v || tk)) begin
      out_w  = held;
      out_v  = 1;
      held_v = 0;
    end else if (out_v && tk) begin
      out_v = 0;
    end
    if (last_acc) begin
      if (s) begin
        if (collecting) exp_err = 1;
        cur_q.delete();
        cur_q.push_back(w);
        collecting = 1;
      end else if (collecting) begin
        cur_q.push_back(w);
        if (cur_q.size() == FW) begin
          for (int k = 0; k < FW; k++) held[k] = cur_q[k];
          held_v     = 1;
          collecting = 0;
          cur_q.delete();
        end
      end else begin
        exp_err = 1;
      end
    end
  endtask

  function automatic logic [HW-1:0] exp_header();
    logic [HW-1:0] r;
    r = '0;
    for (int k = 0; k < HWORDS; k++) r[HW-1-32*k -: 32] = out_w[k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("word_ready", HW'(word_ready), HW'(!held_v));
    chk("job_valid",  HW'(job_valid),  HW'(out_v));
    chk("frame_err",  HW'(frame_err),  HW'(exp_err));
    chk("header",     header,          exp_header());
    chk("nonce",      HW'(nonce),      HW'(out_w[HWORDS]));
    chk("target1",    HW'(target1),    HW'(out_w[HWORDS+1]));
  endtask

  task automatic tick(input logic [31:0] w, input bit wv, input bit s, input bit tk);
    word_in    = w;
    word_valid = wv;
    sof        = s;
    job_taken  = tk;
    @(posedge clk);
    model_step(w, wv, s, tk);
    #1;
    check_outputs();
  endtask

  task automatic add_words(input logic [31:0] base, input int n, input bit sof_first);
    for (int k = 0; k < n; k++) begin
      tx_w.push_back(base + 32'(k));
      tx_s.push_back(sof_first && k == 0);
    end
  endtask

  task automatic send(input int gap_pct, input int take_pct);
    int i;
    int budget;
    bit wv;
    bit tk;
    i = 0;
    budget = 3000;
    while (i < tx_w.size() && budget > 0) begin
      wv = ($urandom_range(99) >= gap_pct);
      tk = ($urandom_range(99) < take_pct);
      tick(tx_w[i], wv, tx_s[i], tk);
      if (last_acc) i++;
      budget--;
    end
    chk("send_done", HW'(i), HW'(tx_w.size()));
    tx_w.delete();
    tx_s.delete();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_header",  header,          '0);
    chk("rst_jobv",    HW'(job_valid),  '0);
    chk("rst_err",     HW'(frame_err),  '0);
    chk("rst_target",  HW'(target1),    '0);
    rst_n = 1'b1;
    tick(32'h0, 0, 0, 0);
    chk("rst_ready", HW'(word_ready), HW'(1));

    // Clean frame, words 1..21
    add_words(32'h1, FW, 1);
    send(0, 0);
    chk("lat_before", HW'(job_valid), HW'(0));
    tick(32'h0, 0, 0, 0);
    chk("clean_jobv",   HW'(job_valid),      HW'(1));
    chk("clean_hdr_hi", HW'(header[607:576]), HW'(32'h1));
    chk("clean_hdr_lo", HW'(header[31:0]),    HW'(32'h13));
    chk("clean_nonce",  HW'(nonce),          HW'(32'h14));
    chk("clean_target", HW'(target1),        HW'(32'h15));
    tick(32'h0, 0, 0, 1);

    // Back-pressure: two frames with nobody taking jobs
    add_words(32'h100, FW, 1);
    add_words(32'h200, FW, 1);
    send(0, 0);
    repeat (3) tick(32'h0, 0, 0, 0);
    chk("bp_ready",  HW'(word_ready),      HW'(0));
    chk("bp_first",  HW'(header[607:576]), HW'(32'h100));
    tick(32'h0, 0, 0, 1);
    chk("bp_jobv",   HW'(job_valid),       HW'(1));
    chk("bp_second", HW'(header[607:576]), HW'(32'h200));
    chk("bp_ready2", HW'(word_ready),      HW'(1));
    tick(32'h0, 0, 0, 1);

    // Restart: sof arrives where word 5 should be
    add_words(32'h300, 5, 1);
    send(0, 0);
    tick(32'h400, 1, 1, 0);
    chk("restart_err", HW'(frame_err), HW'(1));
    add_words(32'h401, FW - 1, 0);
    send(0, 0);
    chk("restart_lat", HW'(job_valid), HW'(0));
    tick(32'h0, 0, 0, 0);
    chk("restart_jobv", HW'(job_valid),       HW'(1));
    chk("restart_hdr",  HW'(header[607:576]), HW'(32'h400));
    chk("restart_tgt",  HW'(target1),         HW'(32'h414));
    tick(32'h0, 0, 0, 1);

    // Stray words while idle
    err_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(32'hDEAD0000 + 32'(i), 1, 0, 0);
      if (frame_err) err_cnt++;
    end
    tick(32'h0, 0, 0, 0);
    chk("stray_errs", HW'(err_cnt),   HW'(3));
    chk("stray_jobv", HW'(job_valid), HW'(0));

    // Reset in the middle of loading, with a job presented
    add_words(32'h500, FW, 1);
    add_words(32'h600, 10, 1);
    send(0, 0);
    word_valid = 1'b0;
    sof        = 1'b0;
    job_taken  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst_header", header,           '0);
    chk("mrst_nonce",  HW'(nonce),       '0);
    chk("mrst_jobv",   HW'(job_valid),   '0);
    chk("mrst_ready",  HW'(word_ready),  HW'(1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(32'h60A, 1, 0, 0);
    add_words(32'h700, FW, 1);
    send(0, 0);
    tick(32'h0, 0, 0, 0);
    chk("mrst_reload", HW'(header[607:576]), HW'(32'h700));
    tick(32'h0, 0, 0, 1);

    // Random words with gaps and random consumer
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < FW; k++) begin
        tx_w.push_back($urandom);
        tx_s.push_back(k == 0);
      end
      send(40, 30);
    end

    // Random stress including sporadic sof
    for (int i = 0; i < 500; i++) begin
      tick($urandom, $urandom_range(99) < 70, $urandom_range(99) < 6, $urandom_range(99) < 25);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/header_loader.md
HEADER_LOADER -- requirements
Module: header_loader

Interface
REQ-001 Parameter HDR_WORDS, default 19, number of 32-bit header words per frame (header width = 32*HDR_WORDS = 608).
REQ-002 Parameter FRAME_WORDS, default HDR_WORDS+2, total words per frame (header, then nonce, then target).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 word_in  input  32  incoming frame word.
REQ-006 word_valid  input  1  word_in valid this cycle.
REQ-007 sof  input  1  start of frame; qualified by word_valid, marks word 0.
REQ-008 word_ready  output  1  loader accepts word_in this cycle.
REQ-009 header  output  608  assembled header for the keccak stage, stable while job_valid=1.
REQ-010 nonce  output  32  starting nonce for the job.
REQ-011 target1  output  32  difficulty target for the job.
REQ-012 job_valid  output  1  header/nonce/target1 hold a complete job.
REQ-013 job_taken  input  1  consumer has latched the job; ignored when job_valid=0.
REQ-014 frame_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-015 A word transfers when word_valid=1 and word_ready=1; no other cycle changes the load buffer.
REQ-016 Word k (0..HDR_WORDS-1) lands in buffer header bits [607-32k : 576-32k] (word 0 is most significant).
REQ-017 Word HDR_WORDS lands in buffer nonce; word HDR_WORDS+1 lands in buffer target.
REQ-018 Load FSM states: IDLE (waiting for sof), LOAD (word counter 1..FRAME_WORDS-1), FULL (complete frame held in load buffer).
REQ-019 IDLE: transfer with sof=1 stores word 0, counter<=1, go LOAD; transfer with sof=0 is dropped and frame_err pulses.
REQ-020 LOAD: transfer with sof=0 stores at counter, counter increments; storing word FRAME_WORDS-1 goes FULL.
REQ-021 LOAD: transfer with sof=1 pulses frame_err, discards the partial frame, stores the word as word 0, counter<=1 (restart).
REQ-022 word_ready=1 in IDLE and LOAD; word_ready=0 in FULL.
REQ-023 FULL with output stage empty (job_valid=0): next edge copies buffer to header/nonce/target1, sets job_valid=1, FSM to IDLE.
REQ-024 Output stage holds its values and job_valid=1 until job_taken=1; that edge clears job_valid.
REQ-025 FULL with job_valid=1 and job_taken=1 in the same cycle: copy buffer, job_valid stays 1, FSM to IDLE (back-to-back jobs, no bubble).
REQ-026 Latency: last word accepted at edge N -> job_valid=1 after edge N+1 when output stage empty.
REQ-027 While job_valid=1 and FSM not FULL, loading of the next frame proceeds (double buffering); outputs never change mid-job.
REQ-028 Counter width ceil(log2(FRAME_WORDS)); never exceeds FRAME_WORDS-1; no wrap.
REQ-029 frame_err is registered, high for exactly one cycle per violation.

Reset
REQ-030 rst_n=0 asynchronously forces FSM IDLE, counter 0, job_valid 0, frame_err 0, header/nonce/target1 all zero; word_ready follows IDLE (1) after release.
REQ-031 Reset mid-frame or mid-job discards all buffered data; the first frame after release must start with sof.
REQ-032 Reset deassertion is synchronized externally; the block adds no synchronizer.

Structure
REQ-033 Shared package holds HDR_WORDS, FRAME_WORDS, header width 608, and the load-state enumeration; keccak stage imports the same widths.
REQ-034 One sub-module, header_outreg, implements the output holding register with job_valid/job_taken handshake; the FSM and buffer stay in header_loader.

Verification
REQ-035 Clean frame: sof + words 0x00000001..0x00000015 back-to-back, job_taken=0 -> job_valid=1 one cycle after last word, header[607:576]=0x00000001, header[31:0]=0x00000013, nonce=0x00000014, target1=0x00000015.
REQ-036 Back-pressure: two frames streamed, job_taken held 0 -> word_ready=0 after 2nd frame complete; pulse job_taken -> 2nd frame appears next cycle with job_valid continuously 1.
REQ-037 Restart: sof at word 5 of a frame -> frame_err one-cycle pulse, job produced only after 21 words counted from the new sof.
REQ-038 Stray data: 3 words with sof=0 in IDLE -> 3 frame_err pulses, no job_valid, buffer unchanged.
REQ-039 Reset mid-load: rst_n low for 1 cycle at word 10 -> outputs zero immediately, job_valid=0; next full frame loads correctly.
REQ-040 Gaps: word_valid toggled randomly within a frame -> identical header/nonce/target1 as gap-free case.
